// File: rtl/dispense_pkg.sv
// Shared types for the dispense sequencer: FSM state encoding and Pi amount codes.
package dispense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STEP_HI,
        STEP_LO,
        RUNOUT,
        DONE
    } state_t;

    localparam logic [1:0] AMT_SMALL = 2'b00;
    localparam logic [1:0] AMT_MED   = 2'b01;
    localparam logic [1:0] AMT_LARGE = 2'b10;
    localparam logic [1:0] AMT_BAD   = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser with asynchronous active-high reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// Turns a Pi dispense request into a counted stepper burst plus DC run-out and handshake.
// Optional: define DISPENSE_ABORT_EN to let a dropped candyflag abort a burst in progress.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 2000,
    parameter int unsigned SMALL_STEPS = 200,
    parameter int unsigned MED_STEPS   = 400,
    parameter int unsigned LARGE_STEPS = 800,
    parameter int unsigned RUNOUT_CYC  = 1040000,
    parameter int unsigned CNT_W       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       candyflag,
    input  logic [1:0] amount,
    output logic       stepper_step,
    output logic       stepper_dir,
    output logic       dc_en,
    output logic       busy,
    output logic       handshake,
    output logic       err
);

`ifdef DISPENSE_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
    localparam logic [31:0] RUN_LAST = (RUNOUT_CYC == 0) ? 32'd0 : 32'(RUNOUT_CYC - 1);

    logic [2:0]       sync_q;
    logic             cf_s;
    logic [1:0]       amt_s;
    logic             cf_prev;
    logic             req_rise;
    state_t           state;
    logic [15:0]      half_cnt;
    logic [31:0]      run_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_next;
    logic [CNT_W-1:0] target;

    sync_2ff #(.W(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({candyflag, amount}),
        .q   (sync_q)
    );

    assign cf_s        = sync_q[2];
    assign amt_s       = sync_q[1:0];
    assign req_rise    = cf_s & ~cf_prev;
    assign step_next   = step_cnt + 1'b1;
    assign stepper_dir = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf_prev <= 1'b0;
        end else begin
            cf_prev <= cf_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            half_cnt     <= '0;
            run_cnt      <= '0;
            step_cnt     <= '0;
            target       <= '0;
            stepper_step <= 1'b0;
            dc_en        <= 1'b0;
            busy         <= 1'b0;
            handshake    <= 1'b0;
            err          <= 1'b0;
        end else if (ABORT_EN && !cf_s &&
                     (state == STEP_HI || state == STEP_LO || state == RUNOUT)) begin
            // Aborted requests never see a handshake.
            state        <= IDLE;
            half_cnt     <= '0;
            run_cnt      <= '0;
            stepper_step <= 1'b0;
            dc_en        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_rise) begin
                        busy <= 1'b1;
                        if (amt_s == AMT_BAD) begin
                            err       <= 1'b1;
                            handshake <= 1'b1;
                            state     <= DONE;
                        end else begin
                            case (amt_s)
                                AMT_SMALL: target <= CNT_W'(SMALL_STEPS);
                                AMT_MED:   target <= CNT_W'(MED_STEPS);
                                default:   target <= CNT_W'(LARGE_STEPS);
                            endcase
                            step_cnt     <= '0;
                            half_cnt     <= '0;
                            dc_en        <= 1'b1;
                            stepper_step <= 1'b1;
                            state        <= STEP_HI;
                        end
                    end
                end
                STEP_HI: begin
                    if (half_cnt == HP_LAST) begin
                        half_cnt     <= '0;
                        stepper_step <= 1'b0;
                        state        <= STEP_LO;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                STEP_LO: begin
                    // A step is only counted once its low phase has finished.
                    if (half_cnt == HP_LAST) begin
                        half_cnt <= '0;
                        step_cnt <= step_next;
                        if (step_next == target) begin
                            run_cnt <= '0;
                            state   <= RUNOUT;
                        end else begin
                            stepper_step <= 1'b1;
                            state        <= STEP_HI;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                RUNOUT: begin
                    if (run_cnt >= RUN_LAST) begin
                        run_cnt   <= '0;
                        dc_en     <= 1'b0;
                        handshake <= 1'b1;
                        state     <= DONE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!cf_s) begin
                        handshake <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with small parameters; DISPENSE_ABORT_EN selects abort expectations.
module tb_dispense_sequencer;

    logic       clk;
    logic       rst;
    logic       candyflag;
    logic [1:0] amount;
    logic       stepper_step;
    logic       stepper_dir;
    logic       dc_en;
    logic       busy;
    logic       handshake;
    logic       err;

    int checks;
    int failures;

    // Monitor counters, cleared per scenario.
    int rises;
    int bad_hi;
    int bad_lo;
    int dc_cycles;
    int hs_cycles;
    int hi_run;
    int lo_run;
    logic step_prev;

    dispense_sequencer #(
        .HALF_PERIOD (2),
        .SMALL_STEPS (5),
        .MED_STEPS   (6),
        .LARGE_STEPS (8),
        .RUNOUT_CYC  (10),
        .CNT_W       (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .candyflag    (candyflag),
        .amount       (amount),
        .stepper_step (stepper_step),
        .stepper_dir  (stepper_dir),
        .dc_en        (dc_en),
        .busy         (busy),
        .handshake    (handshake),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stepper_step && !step_prev) begin
            if (rises > 0 && lo_run != 2) bad_lo = bad_lo + 1;
            rises  = rises + 1;
            lo_run = 0;
        end
        if (stepper_step) begin
            hi_run = hi_run + 1;
        end else begin
            if (step_prev && hi_run != 2) bad_hi = bad_hi + 1;
            if (step_prev) hi_run = 0;
            lo_run = lo_run + 1;
        end
        if (dc_en) dc_cycles = dc_cycles + 1;
        if (handshake) hs_cycles = hs_cycles + 1;
        step_prev = stepper_step;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        rises     = 0;
        bad_hi    = 0;
        bad_lo    = 0;
        dc_cycles = 0;
        hs_cycles = 0;
        hi_run    = 0;
        lo_run    = 0;
    endtask

    task automatic wait_hs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (handshake) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rises(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rises >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        ticks(2);
        checks++;
        if ({stepper_step, stepper_dir, dc_en, busy, handshake, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {stepper_step, stepper_dir, dc_en, busy, handshake, err});
        end
        rst = 1'b0;
        ticks(3);
        checks++;
        if ({stepper_step, dc_en, busy, handshake, err} !== 5'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=00000",
                     {stepper_step, dc_en, busy, handshake, err});
        end
    endtask

    task automatic test_small_burst();
        bit ok;
        clear_mon();
        amount    = 2'b00;
        candyflag = 1'b1;
        ticks(2);
        checks++;
        if (stepper_step !== 1'b0) begin
            failures++;
            $display("FAIL latency_early step=%b want=0", stepper_step);
        end
        tick();
        checks++;
        if (stepper_step !== 1'b1 || dc_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL latency_first_step step=%b dc=%b busy=%b want=1 1 1",
                     stepper_step, dc_en, busy);
        end
        wait_hs(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL small_hs_timeout handshake=%b want=1", handshake);
        end
        checks++;
        if (rises !== 5) begin
            failures++;
            $display("FAIL small_step_count got=%0d want=5", rises);
        end
        checks++;
        if (bad_hi !== 0 || bad_lo !== 0) begin
            failures++;
            $display("FAIL small_step_shape bad_hi=%0d bad_lo=%0d want=0 0", bad_hi, bad_lo);
        end
        checks++;
        if (dc_cycles !== 30) begin
            failures++;
            $display("FAIL small_dc_cycles got=%0d want=30", dc_cycles);
        end
        checks++;
        if (busy !== 1'b1 || dc_en !== 1'b0 || err !== 1'b0 || stepper_dir !== 1'b0) begin
            failures++;
            $display("FAIL small_done_outputs busy=%b dc=%b err=%b dir=%b want=1 0 0 0",
                     busy, dc_en, err, stepper_dir);
        end
    endtask

    task automatic test_hold_done();
        int hs_seen;
        hs_seen = 0;
        clear_mon();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (handshake) hs_seen++;
        end
        checks++;
        if (hs_seen !== 50) begin
            failures++;
            $display("FAIL hold_handshake got=%0d want=50", hs_seen);
        end
        candyflag = 1'b0;
        ticks(2);
        checks++;
        if (handshake !== 1'b1) begin
            failures++;
            $display("FAIL drop_hs_early got=%b want=1", handshake);
        end
        tick();
        checks++;
        if (handshake !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_hs_fall hs=%b busy=%b want=0 0", handshake, busy);
        end
        ticks(20);
        checks++;
        if (rises !== 0) begin
            failures++;
            $display("FAIL hold_no_retrigger rises=%0d want=0", rises);
        end
    endtask

    task automatic test_bad_amount();
        clear_mon();
        amount    = 2'b11;
        candyflag = 1'b1;
        ticks(4);
        checks++;
        if (err !== 1'b1 || handshake !== 1'b1) begin
            failures++;
            $display("FAIL bad_err_hs err=%b hs=%b want=1 1", err, handshake);
        end
        ticks(10);
        checks++;
        if (rises !== 0 || dc_cycles !== 0) begin
            failures++;
            $display("FAIL bad_no_motion rises=%0d dc=%0d want=0 0", rises, dc_cycles);
        end
        candyflag = 1'b0;
        ticks(4);
        checks++;
        if (err !== 1'b0 || handshake !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_clear err=%b hs=%b busy=%b want=0 0 0", err, handshake, busy);
        end
    endtask

    task automatic test_large_amount_change();
        bit ok;
        clear_mon();
        amount    = 2'b10;
        candyflag = 1'b1;
        ticks(10);
        amount = 2'b00;
        wait_hs(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL large_hs_timeout handshake=%b want=1", handshake);
        end
        checks++;
        if (rises !== 8 || dc_cycles !== 42) begin
            failures++;
            $display("FAIL large_count rises=%0d dc=%0d want=8 42", rises, dc_cycles);
        end
        candyflag = 1'b0;
        ticks(4);
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        clear_mon();
        amount    = 2'b00;
        candyflag = 1'b1;
        wait_rises(3, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_mid_timeout rises=%0d want=3", rises);
        end
        rst       = 1'b1;
        candyflag = 1'b0;
        #1;
        checks++;
        if ({stepper_step, dc_en, busy, handshake, err} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%b want=00000",
                     {stepper_step, dc_en, busy, handshake, err});
        end
        ticks(3);
        rst = 1'b0;
        ticks(3);
        clear_mon();
        candyflag = 1'b1;
        wait_hs(200, ok);
        checks++;
        if (!ok || rises !== 5) begin
            failures++;
            $display("FAIL rst_fresh_count ok=%0d rises=%0d want=1 5", ok, rises);
        end
        candyflag = 1'b0;
        ticks(4);
    endtask

    task automatic test_drop_mid_burst();
        bit ok;
        clear_mon();
        amount    = 2'b00;
        candyflag = 1'b1;
        wait_rises(2, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drop_mid_timeout rises=%0d want=2", rises);
        end
        candyflag = 1'b0;
`ifdef DISPENSE_ABORT_EN
        ticks(4);
        checks++;
        if (stepper_step !== 1'b0 || dc_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs step=%b dc=%b busy=%b want=0 0 0",
                     stepper_step, dc_en, busy);
        end
        ticks(40);
        checks++;
        if (hs_cycles !== 0 || rises !== 2) begin
            failures++;
            $display("FAIL abort_no_hs hs=%0d rises=%0d want=0 2", hs_cycles, rises);
        end
`else
        wait_hs(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drop_hs_timeout handshake=%b want=1", handshake);
        end
        wait_idle(20, ok);
        tick();
        checks++;
        if (!ok || hs_cycles !== 1) begin
            failures++;
            $display("FAIL drop_hs_pulse ok=%0d hs_cycles=%0d want=1 1", ok, hs_cycles);
        end
        checks++;
        if (rises !== 5) begin
            failures++;
            $display("FAIL drop_step_count got=%0d want=5", rises);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        step_prev = 1'b0;
        clear_mon();
        rst       = 1'b1;
        candyflag = 1'b0;
        amount    = 2'b00;
        test_reset();
        test_small_burst();
        test_hold_done();
        test_bad_amount();
        test_large_amount_change();
        test_reset_mid_burst();
        test_drop_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Command stage that sits directly upstream of the motor pin drivers. It receives the Raspberry Pi dispense request (candyflag plus a 2-bit amount code) and turns it into a counted burst of stepper steps with the DC agitator running.
- The Pi inputs are asynchronous; the block synchronises them before use.
- When the burst completes, the block raises a handshake and holds it until the Pi drops candyflag. This replaces free-running step output with a step count that is defined for each amount code.

Parameters:
- HALF_PERIOD, 2000, clk cycles per step half-period (2.08 MHz / 4000 = 520 Hz step rate); legal range 2..65535.
- SMALL_STEPS, 200, steps issued for amount 2'b00.
- MED_STEPS, 400, steps issued for amount 2'b01.
- LARGE_STEPS, 800, steps issued for amount 2'b10.
- RUNOUT_CYC, 1040000, clk cycles the DC motor keeps running after the last step (0.5 s).
- CNT_W, 12, width of the step counter; it must hold LARGE_STEPS.

Ports:
- clk  in  1  internal oscillator clock (osc_clk, 2.08 MHz).
- rst  in  1  asynchronous active-high reset.
- candyflag  in  1  asynchronous request level from the Pi.
- amount  in  2  asynchronous amount code from the Pi.
- stepper_step  out  1  step pulse to the stepper driver.
- stepper_dir  out  1  stepper direction; 0 = dispense direction.
- dc_en  out  1  DC motor run enable; the downstream PWM gates this.
- busy  out  1  high in any state other than IDLE.
- handshake  out  1  done indication to the Pi.
- err  out  1  the request carried invalid amount 2'b11.

Behaviour:
- Reset (asynchronous, active-high). The block goes to IDLE immediately. All outputs are 0, all counters are 0, and all synchroniser flops are 0.
- Synchronisation:
  - candyflag and amount each pass through a 2-flop synchroniser.
  - req_rise = synced candyflag is 1 this cycle and was 0 the previous cycle.
  - Input-to-detect latency is 3 clk cycles.
- State IDLE:
  - On req_rise: latch the synced amount.
  - Amount 2'b11: set err=1 and go to DONE. No motion occurs.
  - Any other amount: load target = SMALL_STEPS, MED_STEPS or LARGE_STEPS; clear step_cnt; set dc_en=1; go to STEP_HI.
- State STEP_HI:
  - stepper_step=1 for HALF_PERIOD cycles, then go to STEP_LO.
- State STEP_LO:
  - stepper_step=0 for HALF_PERIOD cycles, then increment step_cnt.
  - If step_cnt reaches target, go to RUNOUT; otherwise go to STEP_HI.
  - A step therefore counts only when its low phase completes, and exactly target rising edges appear on stepper_step.
- State RUNOUT:
  - dc_en stays 1 for RUNOUT_CYC cycles, then dc_en=0 and go to DONE.
  - RUNOUT_CYC=0 means go to DONE on the next cycle.
- State DONE:
  - handshake=1 and busy=1.
  - Remain here while synced candyflag=1.
  - When synced candyflag=0: clear handshake and err on the same edge and go to IDLE.
- stepper_dir is always 0 in this block; the manual jog direction stays in the existing mode decoder.
- Amount changes after the latch have no effect until the next request.
- candyflag dropping mid-burst (STEP_HI/STEP_LO/RUNOUT) has no effect: the burst completes, DONE is entered and exited in consecutive cycles, and handshake pulses for 1 cycle.
- A new request is accepted only from IDLE. candyflag must be seen low and then high again; a request held high through DONE does not retrigger.
- Counter wrap: the half-period counter counts 0..HALF_PERIOD-1 and wraps. The step counter never exceeds target.
- A reset asserted mid-burst aborts immediately with stepper_step=0; there is no resume.

Optional Feature:
- Macro: DISPENSE_ABORT_EN.
- With the macro defined:
  - Synced candyflag=0 in STEP_HI, STEP_LO or RUNOUT forces stepper_step=0 and dc_en=0 on the next edge and goes to IDLE.
  - handshake is never raised for an aborted request.
  - err is cleared.
- Without the macro: the burst always completes, as described in Behaviour.

Decomposition:
- Package dispense_pkg holds:
  - The state enum: IDLE, STEP_HI, STEP_LO, RUNOUT, DONE.
  - Amount code constants: AMT_SMALL=2'b00, AMT_MED=2'b01, AMT_LARGE=2'b10, AMT_BAD=2'b11.
- One sub-module, sync_2ff: a parameterised-width 2-flop synchroniser with asynchronous reset, instantiated once for the 3 bits {candyflag, amount}.

Test Plan:
- HALF_PERIOD=2, SMALL_STEPS=5, RUNOUT_CYC=10; raise candyflag with amount=00 -> exactly 5 stepper_step rising edges, each 2 cycles high and 2 cycles low; dc_en high from the first step until 10 cycles after the last step; handshake=1 afterwards.
- Hold candyflag=1 in DONE for 50 cycles, then drop it -> handshake stays 1, then falls 3 cycles after the drop; busy=0; no new steps.
- amount=11 with candyflag rising -> err=1 and handshake=1 within 4 cycles; stepper_step and dc_en stay 0 throughout.
- amount=10 (LARGE_STEPS=8); toggle amount to 00 mid-burst -> 8 steps are still issued.
- Assert rst mid-burst at step 3 -> all outputs are 0 in the same cycle and the state is IDLE; a fresh request gives a full count.
- Drop candyflag at step 2 of 5: without DISPENSE_ABORT_EN -> 5 steps and a 1-cycle handshake pulse; with it defined -> stepper_step and dc_en are 0 within 4 cycles of the drop, handshake never rises, and busy=0.
